sdf4_digit_reverse_reorder: RTL and testbench

- Output reorder stage directly downstream of the last SdfUnit4 stage in the radix-4 SDF FFT.
- Consumes the 4-lane complex stream, which arrives in base-4 digit-reversed order, and re-emits it in natural order, 4 lanes per cycle.
- Ping-pong double buffer: one bank is written while the other is read, so frames stream back-to-back with no stall.

---
 rtl/fft_pkg.sv | 28 ++
 rtl/sdf4_reorder_bank.sv | 37 +++
 rtl/sdf4_digit_reverse_reorder.sv | 155 +++++++++++++++
 tb/tb_sdf4_digit_reverse_reorder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-4 SDF FFT output path.
//   WIDTH_DEF : default real/imag component width
//   LANES     : complex lanes carried per beat
//   log4      : constant function, number of base-4 digits of a frame length
//   digit_rev : reverses the low 'digits' base-4 digits of an index
package fft_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int LANES     = 4;

    function automatic int log4(input int n);
        int r = 0;
        int v = n;
        while (v > 1) begin
            v = v / 4;
            r++;
        end
        return r;
    endfunction

    function automatic int digit_rev(input int p, input int digits);
        int r = 0;
        for (int i = 0; i < digits; i++)
            r = (r << 2) | ((p >> (2 * i)) & 3);
        return r;
    endfunction

endpackage

// File: rtl/sdf4_reorder_bank.sv
// One bank of the reorder ping-pong buffer: N complex entries ({real,imag}).
//   clk_i      : clock
//   wr_en_i    : per-lane write enable
//   wr_addr_i  : per-lane write address (entries 0..N-1)
//   wr_data_i  : per-lane {real,imag} write data
//   rd_beat_i  : output beat index c; lanes read entries 4c..4c+3
//   rd_data_o  : combinational read data, lane l = entry 4c+l
module sdf4_reorder_bank
    import fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N     = 16,
    localparam int AW   = $clog2(N),
    localparam int BW   = AW - 2
) (
    input  logic                             clk_i,
    input  logic [LANES-1:0]                 wr_en_i,
    input  logic [LANES-1:0][AW-1:0]         wr_addr_i,
    input  logic [LANES-1:0][2*WIDTH-1:0]    wr_data_i,
    input  logic [BW-1:0]                    rd_beat_i,
    output logic [LANES-1:0][2*WIDTH-1:0]    rd_data_o
);

    logic [2*WIDTH-1:0] mem_q [N];

    // Lanes of one beat always target distinct entries, so port order is moot.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < LANES; l++)
            if (wr_en_i[l])
                mem_q[wr_addr_i[l]] <= wr_data_i[l];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_rd
        assign rd_data_o[l] = mem_q[{rd_beat_i, 2'(l)}];
    end

endmodule

// File: rtl/sdf4_digit_reverse_reorder.sv
// Reorders the 4-lane digit-reversed SDF FFT output stream into natural order.
// A frame is written into one bank at digit-reversed addresses while the
// previously completed frame is read out linearly from the other bank.
//   clock, reset (sync, active high)
//   input_en, input_real_0..3, input_imag_0..3   : digit-reversed input beats
//   output_en, output_real_0..3, output_imag_0..3 : natural-order output beats
//   output_last                                   : final beat of each frame
module sdf4_digit_reverse_reorder
    import fft_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEF,
    parameter int Num_of_samples = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             input_en,
    input  logic [WIDTH-1:0] input_real_0,
    input  logic [WIDTH-1:0] input_real_1,
    input  logic [WIDTH-1:0] input_real_2,
    input  logic [WIDTH-1:0] input_real_3,
    input  logic [WIDTH-1:0] input_imag_0,
    input  logic [WIDTH-1:0] input_imag_1,
    input  logic [WIDTH-1:0] input_imag_2,
    input  logic [WIDTH-1:0] input_imag_3,
    output logic             output_en,
    output logic [WIDTH-1:0] output_real_0,
    output logic [WIDTH-1:0] output_real_1,
    output logic [WIDTH-1:0] output_real_2,
    output logic [WIDTH-1:0] output_real_3,
    output logic [WIDTH-1:0] output_imag_0,
    output logic [WIDTH-1:0] output_imag_1,
    output logic [WIDTH-1:0] output_imag_2,
    output logic [WIDTH-1:0] output_imag_3,
    output logic             output_last
);

    localparam int DIGITS = log4(Num_of_samples);
    localparam int BEATS  = Num_of_samples / 4;
    localparam int AW     = $clog2(Num_of_samples);
    localparam int BW     = AW - 2;

    logic [LANES-1:0][2*WIDTH-1:0]          in_data;
    logic [LANES-1:0][AW-1:0]               wr_addr;
    logic [1:0][LANES-1:0][2*WIDTH-1:0]     bank_rd;
    logic [LANES-1:0][2*WIDTH-1:0]          rd_data;

    logic [BW-1:0]                          wr_cnt_q, wr_cnt_d;
    logic                                   wr_bank_q, wr_bank_d;
    logic                                   rd_active_q, rd_active_d;
    logic                                   rd_bank_q, rd_bank_d;
    logic [BW-1:0]                          rd_cnt_q, rd_cnt_d;
    logic                                   out_en_q, out_en_d;
    logic                                   out_last_q, out_last_d;
    logic [LANES-1:0][2*WIDTH-1:0]          out_data_q, out_data_d;

    logic frame_done;
    logic rd_last;

    assign in_data[0] = {input_real_0, input_imag_0};
    assign in_data[1] = {input_real_1, input_imag_1};
    assign in_data[2] = {input_real_2, input_imag_2};
    assign in_data[3] = {input_real_3, input_imag_3};

    always_comb begin
        wr_addr = '0;
        for (int l = 0; l < LANES; l++)
            wr_addr[l] = AW'(digit_rev(4 * int'(wr_cnt_q) + l, DIGITS));
    end

    for (genvar k = 0; k < 2; k++) begin : g_bank
        sdf4_reorder_bank #(
            .WIDTH (WIDTH),
            .N     (Num_of_samples)
        ) u_bank (
            .clk_i     (clock),
            .wr_en_i   ({LANES{input_en && (wr_bank_q == 1'(k))}}),
            .wr_addr_i (wr_addr),
            .wr_data_i (in_data),
            .rd_beat_i (rd_cnt_q),
            .rd_data_o (bank_rd[k])
        );
    end

    assign rd_data    = rd_bank_q ? bank_rd[1] : bank_rd[0];
    assign frame_done = input_en && (wr_cnt_q == BW'(BEATS - 1));
    assign rd_last    = (rd_cnt_q == BW'(BEATS - 1));

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_active_d = rd_active_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        out_en_d    = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = out_data_q;

        if (input_en) begin
            wr_cnt_d = frame_done ? '0 : wr_cnt_q + 1'b1;
            if (frame_done)
                wr_bank_d = ~wr_bank_q;
        end

        if (rd_active_q) begin
            out_en_d   = 1'b1;
            out_last_d = rd_last;
            out_data_d = rd_data;
            rd_cnt_d   = rd_cnt_q + 1'b1;
            if (rd_last)
                rd_active_d = 1'b0;
        end

        // A newly completed frame takes over the read side, even on the
        // same edge as the previous frame's last beat, so output never gaps.
        if (frame_done) begin
            rd_active_d = 1'b1;
            rd_bank_d   = wr_bank_q;
            rd_cnt_d    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_active_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            out_en_q    <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_active_q <= rd_active_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            out_en_q    <= out_en_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign output_en     = out_en_q;
    assign output_last   = out_last_q;
    assign output_real_0 = out_data_q[0][2*WIDTH-1:WIDTH];
    assign output_real_1 = out_data_q[1][2*WIDTH-1:WIDTH];
    assign output_real_2 = out_data_q[2][2*WIDTH-1:WIDTH];
    assign output_real_3 = out_data_q[3][2*WIDTH-1:WIDTH];
    assign output_imag_0 = out_data_q[0][WIDTH-1:0];
    assign output_imag_1 = out_data_q[1][WIDTH-1:0];
    assign output_imag_2 = out_data_q[2][WIDTH-1:0];
    assign output_imag_3 = out_data_q[3][WIDTH-1:0];

endmodule

// File: tb/tb_sdf4_digit_reverse_reorder.sv
// Self-checking bench: N=16 and N=64 instances, expected natural-order beats
// queued when a frame's final input beat is driven, compared as they emerge.
module tb_sdf4_digit_reverse_reorder;

    typedef struct packed {
        logic [3:0][31:0] re;
        logic [3:0][31:0] im;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    beat_t q16[$];
    beat_t q64[$];

    logic        rst16, en16, oen16, olast16;
    logic [31:0] ire16[4], iim16[4], ore16[4], oim16[4];
    logic        rst64, en64, oen64, olast64;
    logic [31:0] ire64[4], iim64[4], ore64[4], oim64[4];

    sdf4_digit_reverse_reorder #(.WIDTH(32), .Num_of_samples(16)) dut16 (
        .clock(clk), .reset(rst16), .input_en(en16),
        .input_real_0(ire16[0]), .input_real_1(ire16[1]), .input_real_2(ire16[2]), .input_real_3(ire16[3]),
        .input_imag_0(iim16[0]), .input_imag_1(iim16[1]), .input_imag_2(iim16[2]), .input_imag_3(iim16[3]),
        .output_en(oen16),
        .output_real_0(ore16[0]), .output_real_1(ore16[1]), .output_real_2(ore16[2]), .output_real_3(ore16[3]),
        .output_imag_0(oim16[0]), .output_imag_1(oim16[1]), .output_imag_2(oim16[2]), .output_imag_3(oim16[3]),
        .output_last(olast16)
    );

    sdf4_digit_reverse_reorder #(.WIDTH(32), .Num_of_samples(64)) dut64 (
        .clock(clk), .reset(rst64), .input_en(en64),
        .input_real_0(ire64[0]), .input_real_1(ire64[1]), .input_real_2(ire64[2]), .input_real_3(ire64[3]),
        .input_imag_0(iim64[0]), .input_imag_1(iim64[1]), .input_imag_2(iim64[2]), .input_imag_3(iim64[3]),
        .output_en(oen64),
        .output_real_0(ore64[0]), .output_real_1(ore64[1]), .output_real_2(ore64[2]), .output_real_3(ore64[3]),
        .output_imag_0(oim64[0]), .output_imag_1(oim64[1]), .output_imag_2(oim64[2]), .output_imag_3(oim64[3]),
        .output_last(olast64)
    );

    // Scoreboard monitors: every valid output beat must match the queue head.
    always @(negedge clk) begin
        if (oen16 === 1'b1) begin
            beat_t a, e;
            a.re = {ore16[3], ore16[2], ore16[1], ore16[0]};
            a.im = {oim16[3], oim16[2], oim16[1], oim16[0]};
            a.last = olast16;
            total++;
            if (q16.size() == 0) begin
                bad++;
                $display("FAIL out16_unexpected got re=%h im=%h last=%b, required no output", a.re, a.im, a.last);
            end else begin
                e = q16.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL out16_beat got re=%h im=%h last=%b, required re=%h im=%h last=%b",
                             a.re, a.im, a.last, e.re, e.im, e.last);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (oen64 === 1'b1) begin
            beat_t a, e;
            a.re = {ore64[3], ore64[2], ore64[1], ore64[0]};
            a.im = {oim64[3], oim64[2], oim64[1], oim64[0]};
            a.last = olast64;
            total++;
            if (q64.size() == 0) begin
                bad++;
                $display("FAIL out64_unexpected got re=%h im=%h last=%b, required no output", a.re, a.im, a.last);
            end else begin
                e = q64.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL out64_beat got re=%h im=%h last=%b, required re=%h im=%h last=%b",
                             a.re, a.im, a.last, e.re, e.im, e.last);
                end
            end
        end
    end

    // Base-4 digit reversal written out per frame size.
    function automatic int dr16(input int p);
        return (p % 4) * 4 + p / 4;
    endfunction

    function automatic int dr64(input int p);
        return (p % 4) * 16 + ((p / 4) % 4) * 4 + p / 16;
    endfunction

    task automatic push_frame16(input int base);
        beat_t e;
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 4; l++) begin
                e.re[l] = 32'(8 * c + 2 * l + 1 + base);
                e.im[l] = 32'(8 * c + 2 * l + base);
            end
            e.last = (c == 3);
            q16.push_back(e);
        end
    endtask

    task automatic drive_beat16(input int b, input int base);
        en16 = 1'b1;
        for (int l = 0; l < 4; l++) begin
            ire16[l] = 32'(2 * dr16(4 * b + l) + 1 + base);
            iim16[l] = 32'(2 * dr16(4 * b + l) + base);
        end
        if (b == 3) push_frame16(base);
    endtask

    // Drives beats where pat is set (frame f offset by base+100*f) and records
    // output_en as seen after each edge.
    task automatic play16(input logic [15:0] pat, input int base, output logic [15:0] hist);
        int b = 0;
        hist = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            hist[i] = oen16;
            if (pat[i]) begin
                drive_beat16(b % 4, base + 100 * (b / 4));
                b++;
            end else begin
                en16 = 1'b0;
            end
        end
        @(posedge clk); #1;
        en16 = 1'b0;
    endtask

    task automatic test_reset;
        rst16 = 1'b1; rst64 = 1'b1; en16 = 1'b0; en64 = 1'b0;
        for (int l = 0; l < 4; l++) begin
            ire16[l] = '0; iim16[l] = '0; ire64[l] = '0; iim64[l] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({oen16, olast16, ore16[0], ore16[1], ore16[2], ore16[3], oim16[0], oim16[1], oim16[2], oim16[3]} !== '0) begin
            bad++;
            $display("FAIL reset16 got en=%b last=%b re0=%h im0=%h, required all zero", oen16, olast16, ore16[0], oim16[0]);
        end
        total++;
        if ({oen64, olast64, ore64[0], ore64[1], ore64[2], ore64[3], oim64[0], oim64[1], oim64[2], oim64[3]} !== '0) begin
            bad++;
            $display("FAIL reset64 got en=%b last=%b re0=%h im0=%h, required all zero", oen64, olast64, ore64[0], oim64[0]);
        end
        rst16 = 1'b0; rst64 = 1'b0;
    endtask

    task automatic test_single;
        logic [15:0] h;
        play16(16'h000F, 0, h);
        total++;
        if (h !== 16'h01E0) begin
            bad++;
            $display("FAIL single_en_timing got %b, required %b", h, 16'h01E0);
        end
        total++;
        if (q16.size() != 0) begin
            bad++;
            $display("FAIL single_drain got %0d beats left, required 0", q16.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] h;
        play16(16'h00FF, 0, h);
        total++;
        if (h !== 16'h1FE0) begin
            bad++;
            $display("FAIL b2b_en_timing got %b, required %b", h, 16'h1FE0);
        end
        total++;
        if (q16.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain got %0d beats left, required 0", q16.size());
        end
    endtask

    task automatic test_gapped;
        logic [15:0] h;
        play16(16'h0055, 0, h);
        total++;
        if (h !== 16'h0F00) begin
            bad++;
            $display("FAIL gapped_en_timing got %b, required %b", h, 16'h0F00);
        end
    endtask

    task automatic test_reset_mid_input;
        logic [15:0] h;
        play16(16'h0003, 50, h);
        total++;
        if (h !== 16'h0000) begin
            bad++;
            $display("FAIL partial_no_output got %b, required %b", h, 16'h0000);
        end
        rst16 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (oen16 !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_en got %b, required 0", oen16);
        end
        rst16 = 1'b0;
        play16(16'h000F, 0, h);
        total++;
        if (h !== 16'h01E0) begin
            bad++;
            $display("FAIL after_reset_en_timing got %b, required %b", h, 16'h01E0);
        end
    endtask

    task automatic test_reset_mid_output;
        int cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive_beat16(i, 200);
        end
        @(posedge clk); #1; en16 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (oen16 !== 1'b1 || olast16 !== 1'b0) begin
            bad++;
            $display("FAIL beat1_present got en=%b last=%b, required en=1 last=0", oen16, olast16);
        end
        rst16 = 1'b1;
        #6;
        q16.delete();
        @(posedge clk); #1;
        rst16 = 1'b0;
        total++;
        if ({oen16, olast16, ore16[0], ore16[1], ore16[2], ore16[3], oim16[0], oim16[1], oim16[2], oim16[3]} !== '0) begin
            bad++;
            $display("FAIL reset_out_clear got en=%b last=%b re0=%h im0=%h, required all zero", oen16, olast16, ore16[0], oim16[0]);
        end
        repeat (8) begin
            @(posedge clk); #1;
            if (oen16 === 1'b1) cnt++;
        end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL reset_out_quiet got %0d beats, required 0", cnt);
        end
    endtask

    task automatic test_n64;
        logic [39:0] h, exp;
        beat_t e;
        h = '0; exp = '0;
        for (int i = 17; i <= 32; i++) exp[i] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            h[i] = oen64;
            if (i < 16) begin
                en64 = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    ire64[l] = 32'(dr64(4 * i + l));
                    iim64[l] = 32'hFFFF_0000 | 32'(dr64(4 * i + l));
                end
                if (i == 15) begin
                    for (int c = 0; c < 16; c++) begin
                        for (int l = 0; l < 4; l++) begin
                            e.re[l] = 32'(4 * c + l);
                            e.im[l] = 32'hFFFF_0000 | 32'(4 * c + l);
                        end
                        e.last = (c == 15);
                        q64.push_back(e);
                    end
                end
            end else begin
                en64 = 1'b0;
            end
        end
        total++;
        if (h !== exp) begin
            bad++;
            $display("FAIL n64_en_timing got %b, required %b", h, exp);
        end
        total++;
        if (q64.size() != 0) begin
            bad++;
            $display("FAIL n64_drain got %0d beats left, required 0", q64.size());
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_gapped;
        test_reset_mid_input;
        test_reset_mid_output;
        test_n64;
        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
